// File: rtl/vram_sync_ctrl_if.sv
// Handshake bundle between the CPU/PPU/sync-writer side and vram_sync_ctrl.
// master drives the request/timing pulses; slave is the controller.
interface vram_sync_ctrl_if #(
    parameter int unsigned FCNT_W = 8
);
    logic              cpu_sync_req;
    logic              vblank_start;
    logic              writer_done;
    logic              swap;
    logic              sync;
    logic              cpu_sync_ack;
    logic              busy;
    logic              pending;
    logic              err;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output cpu_sync_req, vblank_start, writer_done,
        input  swap, sync, cpu_sync_ack, busy, pending, err, frame_cnt
    );

    modport slave (
        input  cpu_sync_req, vblank_start, writer_done,
        output swap, sync, cpu_sync_ack, busy, pending, err, frame_cnt
    );
endinterface

// File: rtl/vram_sync_ctrl.sv
// Frame-level VRAM bank-swap controller: latch CPU request, swap at vblank, run the
// writer copy, ack the CPU. Define VRAM_SYNC_TIMEOUT_EN to build the copy watchdog.
module vram_sync_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned FCNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    vram_sync_ctrl_if.slave  ctrl_io
);
    typedef enum logic [2:0] {StIdle, StArmed, StSwap, StSync, StWait, StAck} state_e;

    state_e            state_q;
    logic              second_q;
    logic              swap_q;
    logic              sync_q;
    logic              ack_q;
    logic              busy_q;
    logic              pending_q;
    logic              err_q;
    logic [FCNT_W-1:0] frame_cnt_q;

`ifdef VRAM_SYNC_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] wait_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            second_q    <= 1'b0;
            swap_q      <= 1'b0;
            sync_q      <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
`ifdef VRAM_SYNC_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            swap_q <= 1'b0;
            sync_q <= 1'b0;
            ack_q  <= 1'b0;
            unique case (state_q)
                // A vblank coinciding with the request is deliberately not used.
                StIdle: begin
                    if (ctrl_io.cpu_sync_req) begin
                        state_q   <= StArmed;
                        pending_q <= 1'b1;
                    end
                end
                StArmed: begin
                    if (ctrl_io.vblank_start) begin
                        state_q   <= StSwap;
                        swap_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                StSwap: begin
                    state_q <= StSync;
                    sync_q  <= 1'b1;
                    if (ctrl_io.cpu_sync_req) second_q <= 1'b1;
                end
                StSync: begin
                    state_q <= StWait;
`ifdef VRAM_SYNC_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    if (ctrl_io.cpu_sync_req) second_q <= 1'b1;
                end
                StWait: begin
                    if (ctrl_io.cpu_sync_req) second_q <= 1'b1;
                    if (ctrl_io.writer_done) begin
                        state_q     <= StAck;
                        ack_q       <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                    end
`ifdef VRAM_SYNC_TIMEOUT_EN
                    else if (wait_cnt_q == CntLast) begin
                        // Abort drops any queued second request along with the copy.
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b1;
                        second_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                StAck: begin
                    busy_q   <= 1'b0;
                    second_q <= 1'b0;
                    if (second_q || ctrl_io.cpu_sync_req) begin
                        state_q   <= StArmed;
                        pending_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctrl_io.swap         = swap_q;
    assign ctrl_io.sync         = sync_q;
    assign ctrl_io.cpu_sync_ack = ack_q;
    assign ctrl_io.busy         = busy_q;
    assign ctrl_io.pending      = pending_q;
    assign ctrl_io.err          = err_q;
    assign ctrl_io.frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_vram_sync_ctrl.sv
// Self-checking bench for vram_sync_ctrl: directed scenarios plus random pulses, every
// cycle compared against a transaction-level reference model.
module tb_vram_sync_ctrl;
    localparam int unsigned FW = 4;
`ifdef VRAM_SYNC_TIMEOUT_EN
    localparam int unsigned TO   = 64;
    localparam bit          WdOn = 1'b1;
    localparam int          CopyLat = 40;
`else
    localparam int unsigned TO   = 4096;
    localparam bit          WdOn = 1'b0;
    localparam int          CopyLat = 2051;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    vram_sync_ctrl_if #(.FCNT_W(FW)) bus ();

    vram_sync_ctrl #(.TIMEOUT_CYCLES(TO), .FCNT_W(FW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: request/transfer bookkeeping in plain terms.
    bit m_pend, m_busy, m_ackph, m_second, m_err;
    int m_age;     // 1 = swap cycle, 2 = sync cycle, 3 = waiting for the writer
    int m_wcnt;
    int m_frames;

    function automatic void model_reset();
        m_pend = 0; m_busy = 0; m_ackph = 0; m_second = 0; m_err = 0;
        m_age = 0; m_wcnt = 0; m_frames = 0;
    endfunction

    function automatic void model_step(bit req, bit vb, bit done);
        if (m_busy) begin
            if (req) m_second = 1;
            if (m_ackph) begin
                m_ackph = 0; m_busy = 0; m_pend = m_second; m_second = 0;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2) begin
                m_age = 3; m_wcnt = 0;
            end else if (done) begin
                m_ackph = 1; m_frames = (m_frames + 1) % (1 << FW);
            end else if (WdOn && m_wcnt == int'(TO) - 1) begin
                m_busy = 0; m_err = 1; m_second = 0;
            end else begin
                m_wcnt++;
            end
        end else if (m_pend) begin
            if (vb) begin m_busy = 1; m_age = 1; m_pend = 0; end
        end else if (req) begin
            m_pend = 1;
        end
    endfunction

    task automatic compare_all();
        check_val("swap",    32'(bus.swap),         32'(m_busy && !m_ackph && m_age == 1));
        check_val("sync",    32'(bus.sync),         32'(m_busy && !m_ackph && m_age == 2));
        check_val("ack",     32'(bus.cpu_sync_ack), 32'(m_ackph));
        check_val("busy",    32'(bus.busy),         32'(m_busy));
        check_val("pending", 32'(bus.pending),      32'(m_pend));
        check_val("err",     32'(bus.err),          32'(m_err));
        check_val("frames",  32'(bus.frame_cnt),    32'(m_frames));
    endtask

    task automatic cyc(input bit req, input bit vb, input bit done);
        bus.cpu_sync_req = req;
        bus.vblank_start = vb;
        bus.writer_done  = done;
        @(posedge clk);
        model_step(req, vb, done);
        #1;
        bus.cpu_sync_req = 1'b0;
        bus.vblank_start = 1'b0;
        bus.writer_done  = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        bus.cpu_sync_req = 1'b0;
        bus.vblank_start = 1'b0;
        bus.writer_done  = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Basic swap.
        idle(4);
        cyc(1, 0, 0);
        idle(14);
        cyc(0, 1, 0);
        check_val("basic_swap", 32'(bus.swap), 32'd1);
        cyc(0, 0, 0);
        check_val("basic_sync", 32'(bus.sync), 32'd1);
        idle(CopyLat);
        cyc(0, 0, 1);
        check_val("basic_ack", 32'(bus.cpu_sync_ack), 32'd1);
        check_val("basic_frames", 32'(bus.frame_cnt), 32'd1);
        cyc(0, 0, 0);
        check_val("basic_busy_fall", 32'(bus.busy), 32'd0);

        // Request and vblank together: that vblank is not used.
        idle(3);
        cyc(1, 1, 0);
        idle(5);
        check_val("same_no_swap", 32'(bus.pending), 32'd1);
        cyc(0, 1, 0);
        check_val("same_late_swap", 32'(bus.swap), 32'd1);
        idle(6);
        cyc(0, 0, 1);
        idle(2);

        // Requests while busy coalesce into one more swap.
        do_reset();
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        idle(3);
        cyc(1, 0, 0);
        idle(2);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check_val("second_pending", 32'(bus.pending), 32'd1);
        idle(4);
        cyc(0, 1, 0);
        check_val("second_swap", 32'(bus.swap), 32'd1);
        idle(5);
        cyc(0, 0, 1);
        idle(3);
        check_val("second_frames", 32'(bus.frame_cnt), 32'd2);
        check_val("second_idle", 32'(bus.pending), 32'd0);

        // Stray pulses with nothing requested.
        do_reset();
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        idle(3);
        check_val("stray_frames", 32'(bus.frame_cnt), 32'd0);

        // Reset mid-copy: late done must not ack.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        idle(1);
        idle(WdOn ? 30 : 100);
        do_reset();
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        cyc(0, 0, 1);
        check_val("rst_no_ack", 32'(bus.cpu_sync_ack), 32'd0);
        idle(2);

`ifdef VRAM_SYNC_TIMEOUT_EN
        // Watchdog: withheld done aborts after TO wait cycles.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        idle(1 + int'(TO));
        check_val("wd_err", 32'(bus.err), 32'd1);
        check_val("wd_busy", 32'(bus.busy), 32'd0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        idle(5);
        cyc(0, 0, 1);
        check_val("wd_ack", 32'(bus.cpu_sync_ack), 32'd1);
        check_val("wd_err_sticky", 32'(bus.err), 32'd1);
        idle(2);
`endif

        // Random pulses, including occasional reset; wraps frame_cnt.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 14) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_sync_ctrl.md
# vram_sync_ctrl

Frame-level controller sitting directly upstream of the VRAM sync writer. It latches CPU buffer-swap requests, waits for the PPU's vertical-blank boundary, swaps the CPU/PPU VRAM banks, then pulses `sync` so the writer copies the newly displayed bank back into the CPU bank. It reports completion to the CPU side once the writer's `done` returns. This keeps the PPU from ever displaying a half-written frame.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: watchdog limit on the writer copy; the nominal copy is ~2052 cycles at 50 MHz. Only used when the watchdog is compiled in.
- `FCNT_W`, 8: width of the completed-swap counter.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_sync_req`  in  1  1-cycle pulse: CPU has finished writing its bank and requests a swap.
- `vblank_start`  in  1  1-cycle pulse from PPU timing at the first cycle of vertical blank.
- `writer_done`  in  1  1-cycle pulse from the sync writer: copy finished.
- `swap`  out  1  1-cycle pulse to VRAM: exchange CPU/PPU banks.
- `sync`  out  1  1-cycle pulse to the sync writer: start the copy.
- `cpu_sync_ack`  out  1  1-cycle pulse: swap and copy are complete; the CPU bank is writable again.
- `busy`  out  1  high from the swap pulse until ack or abort; the CPU must not write VRAM while high.
- `pending`  out  1  a request is latched and waiting for vblank.
- `frame_cnt`  out  FCNT_W  count of completed swaps; wraps modulo 2^FCNT_W.
- `err`  out  1  sticky watchdog error.

## Operation
- FSM states: IDLE, ARMED, SWAP, SYNC, WAIT, ACK.
- IDLE: `cpu_sync_req` latches a request and moves to ARMED.
- ARMED: `pending`=1. On `vblank_start`, go to SWAP.
- SWAP: `swap`=1 for exactly one cycle, then go to SYNC.
- SYNC: `sync`=1 for exactly one cycle, then go to WAIT.
- WAIT: wait for `writer_done`, then go to ACK.
- ACK: `cpu_sync_ack`=1 for one cycle and `frame_cnt`++.
  - Next state is ARMED if a second request was latched, otherwise IDLE.
- `busy`=1 in SWAP, SYNC, WAIT and ACK.
- Boundary conditions:
  - `cpu_sync_req` and `vblank_start` in the same IDLE cycle: the request is latched only. That vblank is not used; the swap waits for the next one.
  - `cpu_sync_req` in ARMED: ignored, coalesced into the existing request.
  - `cpu_sync_req` in SWAP, SYNC, WAIT or ACK: sets a one-deep second-request flag. Further requests coalesce into it. The flag clears when ACK consumes it.
  - `vblank_start` outside ARMED: ignored.
  - `writer_done` outside WAIT: ignored.
  - `frame_cnt` at all-ones: the next ACK wraps it to 0.
  - `rst` mid-operation: the FSM returns to IDLE immediately and all latched requests are lost. No further `swap`, `sync` or ack is issued.
- Reset values: state IDLE; `swap`, `sync`, `cpu_sync_ack`, `busy`, `pending`, `err` = 0; `frame_cnt` = 0.

## Timing
- All outputs are registered.
- Latency from `vblank_start` at cycle N (in ARMED):
  - `swap` high in cycle N+1.
  - `sync` high in cycle N+2.
  - `busy` rises in cycle N+1.
- Latency from `writer_done` at cycle M (in WAIT):
  - `cpu_sync_ack` high in cycle M+1; `frame_cnt` updates in the same cycle.
  - `busy` falls in cycle M+2.
- Request latched at cycle R: `pending` is high from cycle R+1.
- `swap` and `sync` are never high in the same cycle.
- Exactly one `sync` is issued per `swap`.

## Configuration
- `VRAM_SYNC_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT, cleared on WAIT entry.
  - If TIMEOUT_CYCLES cycles elapse in WAIT without `writer_done`, the FSM goes to IDLE with no ack and sets `err`=1.
  - `err` is sticky until `rst`.
  - The second-request flag is discarded on abort.
- `VRAM_SYNC_TIMEOUT_EN` undefined:
  - No counter is built and `err` is tied to 0.
  - WAIT waits indefinitely.

## Test plan
- Basic swap: reset, then `cpu_sync_req` at cycle 5 and `vblank_start` at cycle 20.
  - Required: `swap` at 21, `sync` at 22.
  - Bench returns `writer_done` at 2074. Required: `cpu_sync_ack` at 2075, `frame_cnt`=1, `busy`=0 at 2076.
- Same-cycle request and vblank: `cpu_sync_req` and `vblank_start` both at cycle 10.
  - Required: no `swap`.
  - Next `vblank_start` at 300: `swap` at 301.
- Request during busy: second `cpu_sync_req` during WAIT, third also during WAIT.
  - Required: after ack, `pending`=1.
  - Exactly one more swap occurs at the next vblank; `frame_cnt` ends at 2.
- Stray pulses: `vblank_start` and `writer_done` in IDLE with no request.
  - Required: no `swap`, `sync` or `cpu_sync_ack`; `frame_cnt` stays 0.
- Reset during WAIT: assert `rst` 100 cycles after `sync`, then release.
  - Required: all outputs 0 immediately.
  - A late `writer_done` produces no ack.
- Watchdog (macro defined, TIMEOUT_CYCLES=64): withhold `writer_done`.
  - Required: `err`=1 and `busy`=0 after 64 WAIT cycles, no ack.
  - A later request and swap still complete normally with `err` remaining 1.
